// File: rtl/param_fifo_if.sv
// Bundle of request, status and data signals for param_fifo.
// master : the block that writes, reads, flushes and sets thresholds.
// slave  : the FIFO itself.
// Signals:
//   flush, wr_en, wr_data, rd_en, err_clr, a_full_thr, a_empty_thr  (master -> slave)
//   rd_data, rd_valid, full, empty, a_full, a_empty, level,
//   overflow, underflow                                             (slave -> master)
interface param_fifo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              err_clr;
  logic [LVL_W-1:0]  a_full_thr;
  logic [LVL_W-1:0]  a_empty_thr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              a_full;
  logic              a_empty;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en, err_clr, a_full_thr, a_empty_thr,
    input  rd_data, rd_valid, full, empty, a_full, a_empty, level, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, err_clr, a_full_thr, a_empty_thr,
    output rd_data, rd_valid, full, empty, a_full, a_empty, level, overflow, underflow
  );
endinterface

// File: rtl/param_fifo.sv
// Synchronous single-clock FIFO with any depth >= 2, runtime almost-full/almost-empty
// thresholds, synchronous flush, sticky overflow/underflow flags and a choice of
// first-word-fall-through (FWFT=1) or registered one-cycle-latency read (FWFT=0).
// Ports:
//   clk    : sole clock, rising edge
//   rst_n  : synchronous active-low reset; clears pointers, level, flags and storage
//   bus    : param_fifo_if slave modport (requests in, data/status out)
module param_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned FWFT   = 1
) (
  input logic         clk,
  input logic         rst_n,
  param_fifo_if.slave bus
);

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PtrLast = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LvlFull = LVL_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              a_full_q, a_full_d;
  logic              a_empty_q, a_empty_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc;

  always_comb begin
    // Acceptance uses the registered full/empty, so a full FIFO refuses a write even
    // when a read frees a slot in the same cycle.
    wr_acc = bus.wr_en & ~full_q & ~bus.flush;
    rd_acc = bus.rd_en & ~empty_q & ~bus.flush;

    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;

    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
    end else begin
      if (wr_acc) tail_d = (tail_q == PtrLast) ? '0 : tail_q + 1'b1;
      if (rd_acc) head_d = (head_q == PtrLast) ? '0 : head_q + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end

    // Flags follow the next level and the thresholds presented this cycle.
    full_d    = (level_d == LvlFull);
    empty_d   = (level_d == '0);
    a_full_d  = (level_d >= bus.a_full_thr);
    a_empty_d = (level_d <= bus.a_empty_thr);

    // A fresh error condition beats err_clr in the same cycle.
    overflow_d  = (bus.wr_en & full_q & ~bus.flush) | (overflow_q & ~bus.err_clr);
    underflow_d = (bus.rd_en & empty_q & ~bus.flush) | (underflow_q & ~bus.err_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      a_full_q    <= 1'b0;
      a_empty_q   <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) mem_q[tail_q] <= bus.wr_data;
      head_q      <= head_d;
      tail_q      <= tail_d;
      level_q     <= level_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      a_full_q    <= a_full_d;
      a_empty_q   <= a_empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head entry is visible whenever the FIFO holds anything.
    assign bus.rd_data  = mem_q[head_q];
    assign bus.rd_valid = ~empty_q;
  end else begin : g_reg_rd
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    // rd_valid is a one-cycle pulse per accepted read; rd_data holds between reads.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem_q[head_q];
      end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
  end

  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.a_full    = a_full_q;
  assign bus.a_empty   = a_empty_q;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: three instances (DEPTH=8 FWFT, DEPTH=5 FWFT,
// DEPTH=8 registered read) sharing one clock and reset.
module tb_param_fifo;

  logic clk = 1'b0;
  logic rst_n;
  int   checks_total  = 0;
  int   checks_passed = 0;

  always #5 clk = ~clk;

  param_fifo_if #(.DATA_W(8), .DEPTH(8)) a_if ();
  param_fifo_if #(.DATA_W(8), .DEPTH(5)) b_if ();
  param_fifo_if #(.DATA_W(8), .DEPTH(8)) c_if ();

  param_fifo #(.DATA_W(8), .DEPTH(8), .FWFT(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  param_fifo #(.DATA_W(8), .DEPTH(5), .FWFT(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  param_fifo #(.DATA_W(8), .DEPTH(8), .FWFT(0)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks_total++;
    if (a_if.level !== 4'd0) $display("FAIL reset_level: got %0d want 0", a_if.level);
    else checks_passed++;
    checks_total++;
    if ({a_if.full, a_if.empty, a_if.a_full, a_if.a_empty} !== 4'b0101)
      $display("FAIL reset_flags: got %b want 0101",
               {a_if.full, a_if.empty, a_if.a_full, a_if.a_empty});
    else checks_passed++;
    checks_total++;
    if ({a_if.overflow, a_if.underflow, a_if.rd_valid, a_if.rd_data} !== 11'd0)
      $display("FAIL reset_err_rd: got %b/%b/%b/%h want 0/0/0/00",
               a_if.overflow, a_if.underflow, a_if.rd_valid, a_if.rd_data);
    else checks_passed++;
    checks_total++;
    if ({c_if.rd_valid, c_if.rd_data} !== 9'd0)
      $display("FAIL reset_reg_rd: got %b/%h want 0/00", c_if.rd_valid, c_if.rd_data);
    else checks_passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    logic [3:0] exp_flags;
    for (int i = 1; i <= 8; i++) begin
      a_if.wr_en   = 1'b1;
      a_if.wr_data = 8'(i);
      tick();
      exp_flags = {(i == 8), 1'b0, (i >= 6), (i <= 2)};
      checks_total++;
      if (a_if.level !== 4'(i)) $display("FAIL fill_level_%0d: got %0d want %0d", i, a_if.level, i);
      else checks_passed++;
      checks_total++;
      if ({a_if.full, a_if.empty, a_if.a_full, a_if.a_empty} !== exp_flags)
        $display("FAIL fill_flags_%0d: got %b want %b", i,
                 {a_if.full, a_if.empty, a_if.a_full, a_if.a_empty}, exp_flags);
      else checks_passed++;
    end
    checks_total++;
    if (a_if.rd_data !== 8'h01) $display("FAIL fill_head: got %h want 01", a_if.rd_data);
    else checks_passed++;
    a_if.wr_data = 8'h09;
    tick();
    a_if.wr_en = 1'b0;
    checks_total++;
    if ({a_if.overflow, a_if.full, a_if.level} !== 6'b11_1000)
      $display("FAIL fill_overflow: got ovf=%b full=%b lvl=%0d want 1/1/8",
               a_if.overflow, a_if.full, a_if.level);
    else checks_passed++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_data;
    // Full: only the read is accepted.
    a_if.wr_en   = 1'b1;
    a_if.rd_en   = 1'b1;
    a_if.wr_data = 8'hEE;
    tick();
    a_if.wr_en = 1'b0;
    checks_total++;
    if ({a_if.level, a_if.full, a_if.rd_data} !== {4'd7, 1'b0, 8'h02})
      $display("FAIL full_rw: got lvl=%0d full=%b head=%h want 7/0/02",
               a_if.level, a_if.full, a_if.rd_data);
    else checks_passed++;
    for (int i = 0; i < 3; i++) tick();
    a_if.rd_en = 1'b0;
    checks_total++;
    if ({a_if.level, a_if.rd_data} !== {4'd4, 8'h05})
      $display("FAIL drain_to_4: got lvl=%0d head=%h want 4/05", a_if.level, a_if.rd_data);
    else checks_passed++;
    for (int k = 0; k < 10; k++) begin
      a_if.wr_en   = 1'b1;
      a_if.rd_en   = 1'b1;
      a_if.wr_data = 8'(8'h10 + k);
      exp_data     = (k < 4) ? 8'(5 + k) : 8'(8'h10 + k - 4);
      checks_total++;
      if (a_if.rd_data !== exp_data)
        $display("FAIL rw_data_%0d: got %h want %h", k, a_if.rd_data, exp_data);
      else checks_passed++;
      tick();
      checks_total++;
      if ({a_if.level, a_if.full, a_if.empty, a_if.a_full, a_if.a_empty} !== 8'b0100_0000)
        $display("FAIL rw_state_%0d: got lvl=%0d flags=%b want 4/0000", k, a_if.level,
                 {a_if.full, a_if.empty, a_if.a_full, a_if.a_empty});
      else checks_passed++;
    end
    a_if.wr_en = 1'b0;
    a_if.rd_en = 1'b0;
    checks_total++;
    if ({a_if.rd_data, a_if.overflow} !== {8'h16, 1'b1})
      $display("FAIL rw_tail: got head=%h ovf=%b want 16/1", a_if.rd_data, a_if.overflow);
    else checks_passed++;
    a_if.err_clr = 1'b1;
    tick();
    a_if.err_clr = 1'b0;
    checks_total++;
    if (a_if.overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", a_if.overflow);
    else checks_passed++;
  endtask

  task automatic test_flush();
    a_if.wr_en   = 1'b1;
    a_if.wr_data = 8'h20;
    tick();
    checks_total++;
    if (a_if.level !== 4'd5) $display("FAIL pre_flush_level: got %0d want 5", a_if.level);
    else checks_passed++;
    a_if.flush   = 1'b1;
    a_if.wr_data = 8'h77;
    tick();
    a_if.flush = 1'b0;
    a_if.wr_en = 1'b0;
    checks_total++;
    if ({a_if.level, a_if.full, a_if.empty, a_if.a_full, a_if.a_empty, a_if.rd_valid}
        !== 9'b0000_0101_0)
      $display("FAIL flush_state: got lvl=%0d flags=%b valid=%b want 0/0101/0", a_if.level,
               {a_if.full, a_if.empty, a_if.a_full, a_if.a_empty}, a_if.rd_valid);
    else checks_passed++;
    a_if.rd_en = 1'b1;
    tick();
    checks_total++;
    if ({a_if.underflow, a_if.level} !== 5'b1_0000)
      $display("FAIL underflow_set: got udf=%b lvl=%0d want 1/0", a_if.underflow, a_if.level);
    else checks_passed++;
    a_if.err_clr = 1'b1;
    tick();
    a_if.rd_en = 1'b0;
    checks_total++;
    if (a_if.underflow !== 1'b1) $display("FAIL set_beats_clr: got %b want 1", a_if.underflow);
    else checks_passed++;
    tick();
    a_if.err_clr = 1'b0;
    checks_total++;
    if (a_if.underflow !== 1'b0) $display("FAIL udf_clear: got %b want 0", a_if.underflow);
    else checks_passed++;
    a_if.wr_en   = 1'b1;
    a_if.wr_data = 8'h33;
    tick();
    a_if.wr_en = 1'b0;
    checks_total++;
    if ({a_if.level, a_if.rd_data} !== {4'd1, 8'h33})
      $display("FAIL post_flush_write: got lvl=%0d head=%h want 1/33", a_if.level, a_if.rd_data);
    else checks_passed++;
  endtask

  task automatic test_thresholds();
    a_if.wr_en = 1'b1;
    a_if.wr_data = 8'h34;
    tick();
    a_if.wr_data = 8'h35;
    tick();
    a_if.wr_en = 1'b0;
    checks_total++;
    if ({a_if.level, a_if.a_full, a_if.a_empty} !== 6'b0011_00)
      $display("FAIL thr_before: got lvl=%0d af=%b ae=%b want 3/0/0",
               a_if.level, a_if.a_full, a_if.a_empty);
    else checks_passed++;
    a_if.a_full_thr = 4'd3;
    tick();
    checks_total++;
    if ({a_if.level, a_if.a_full} !== 5'b0011_1)
      $display("FAIL thr_afull: got lvl=%0d af=%b want 3/1", a_if.level, a_if.a_full);
    else checks_passed++;
    a_if.a_empty_thr = 4'd3;
    tick();
    checks_total++;
    if (a_if.a_empty !== 1'b1) $display("FAIL thr_aempty: got %b want 1", a_if.a_empty);
    else checks_passed++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) begin
      b_if.wr_en   = 1'b1;
      b_if.wr_data = 8'(8'h41 + i);
      tick();
    end
    b_if.wr_en = 1'b0;
    checks_total++;
    if ({b_if.level, b_if.full} !== 4'b101_1)
      $display("FAIL wrap_fill: got lvl=%0d full=%b want 5/1", b_if.level, b_if.full);
    else checks_passed++;
    for (int i = 0; i < 3; i++) begin
      checks_total++;
      if (b_if.rd_data !== 8'(8'h41 + i))
        $display("FAIL wrap_rd1_%0d: got %h want %h", i, b_if.rd_data, 8'(8'h41 + i));
      else checks_passed++;
      b_if.rd_en = 1'b1;
      tick();
    end
    b_if.rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_if.wr_en   = 1'b1;
      b_if.wr_data = 8'(8'h46 + i);
      tick();
    end
    b_if.wr_en = 1'b0;
    checks_total++;
    if ({b_if.level, b_if.full} !== 4'b101_1)
      $display("FAIL wrap_refill: got lvl=%0d full=%b want 5/1", b_if.level, b_if.full);
    else checks_passed++;
    for (int i = 0; i < 5; i++) begin
      checks_total++;
      if (b_if.rd_data !== 8'(8'h44 + i))
        $display("FAIL wrap_rd2_%0d: got %h want %h", i, b_if.rd_data, 8'(8'h44 + i));
      else checks_passed++;
      b_if.rd_en = 1'b1;
      tick();
    end
    b_if.rd_en = 1'b0;
    checks_total++;
    if ({b_if.level, b_if.empty} !== 4'b000_1)
      $display("FAIL wrap_drain: got lvl=%0d empty=%b want 0/1", b_if.level, b_if.empty);
    else checks_passed++;
  endtask

  task automatic test_registered_read();
    c_if.wr_en   = 1'b1;
    c_if.wr_data = 8'hA5;
    tick();
    c_if.wr_en = 1'b0;
    checks_total++;
    if ({c_if.rd_valid, c_if.level} !== 5'b0_0001)
      $display("FAIL reg_idle: got valid=%b lvl=%0d want 0/1", c_if.rd_valid, c_if.level);
    else checks_passed++;
    c_if.rd_en = 1'b1;
    tick();
    c_if.rd_en = 1'b0;
    checks_total++;
    if ({c_if.rd_valid, c_if.rd_data} !== {1'b1, 8'hA5})
      $display("FAIL reg_pop: got %b/%h want 1/a5", c_if.rd_valid, c_if.rd_data);
    else checks_passed++;
    tick();
    checks_total++;
    if ({c_if.rd_valid, c_if.rd_data} !== {1'b0, 8'hA5})
      $display("FAIL reg_hold: got %b/%h want 0/a5", c_if.rd_valid, c_if.rd_data);
    else checks_passed++;
    c_if.wr_en   = 1'b1;
    c_if.wr_data = 8'h11;
    tick();
    c_if.wr_data = 8'h22;
    tick();
    c_if.wr_en = 1'b0;
    c_if.rd_en = 1'b1;
    tick();
    checks_total++;
    if ({c_if.rd_valid, c_if.rd_data} !== {1'b1, 8'h11})
      $display("FAIL reg_pop2: got %b/%h want 1/11", c_if.rd_valid, c_if.rd_data);
    else checks_passed++;
    c_if.flush = 1'b1;
    tick();
    c_if.flush = 1'b0;
    c_if.rd_en = 1'b0;
    checks_total++;
    if ({c_if.rd_valid, c_if.rd_data, c_if.level} !== {1'b0, 8'h11, 4'd0})
      $display("FAIL reg_flush: got %b/%h/%0d want 0/11/0",
               c_if.rd_valid, c_if.rd_data, c_if.level);
    else checks_passed++;
  endtask

  task automatic test_reset_mid();
    a_if.wr_en   = 1'b1;
    a_if.rd_en   = 1'b1;
    a_if.err_clr = 1'b1;
    a_if.wr_data = 8'h99;
    rst_n        = 1'b0;
    tick();
    checks_total++;
    if ({a_if.level, a_if.full, a_if.empty, a_if.a_full, a_if.a_empty} !== 8'b0000_0101)
      $display("FAIL rst_mid_state: got lvl=%0d flags=%b want 0/0101", a_if.level,
               {a_if.full, a_if.empty, a_if.a_full, a_if.a_empty});
    else checks_passed++;
    checks_total++;
    if ({a_if.overflow, a_if.underflow, a_if.rd_valid, a_if.rd_data} !== 11'd0)
      $display("FAIL rst_mid_rd: got %b/%b/%b/%h want 0/0/0/00",
               a_if.overflow, a_if.underflow, a_if.rd_valid, a_if.rd_data);
    else checks_passed++;
    checks_total++;
    if ({c_if.rd_valid, c_if.rd_data} !== 9'd0)
      $display("FAIL rst_mid_reg: got %b/%h want 0/00", c_if.rd_valid, c_if.rd_data);
    else checks_passed++;
    a_if.wr_en   = 1'b0;
    a_if.rd_en   = 1'b0;
    a_if.err_clr = 1'b0;
    rst_n        = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    a_if.flush = 1'b0; a_if.wr_en = 1'b0; a_if.wr_data = '0; a_if.rd_en = 1'b0;
    a_if.err_clr = 1'b0; a_if.a_full_thr = 4'd6; a_if.a_empty_thr = 4'd2;
    b_if.flush = 1'b0; b_if.wr_en = 1'b0; b_if.wr_data = '0; b_if.rd_en = 1'b0;
    b_if.err_clr = 1'b0; b_if.a_full_thr = 3'd4; b_if.a_empty_thr = 3'd1;
    c_if.flush = 1'b0; c_if.wr_en = 1'b0; c_if.wr_data = '0; c_if.rd_en = 1'b0;
    c_if.err_clr = 1'b0; c_if.a_full_thr = 4'd6; c_if.a_empty_thr = 4'd2;

    test_reset();
    test_fill();
    test_simultaneous();
    test_flush();
    test_thresholds();
    test_wrap();
    test_registered_read();
    test_reset_mid();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
